// File: rtl/rect_fill_controller_pkg.sv
// Shared video definitions: bus opcodes, default bitmap geometry and the bus
// record, reused by the video card and by the rectangle fill engine.
package rect_fill_controller_pkg;

  localparam int VID_IN_WIDTH  = 320;
  localparam int VID_IN_HEIGHT = 240;

  localparam logic [1:0] VID_OP_NONE  = 2'b00;
  localparam logic [1:0] VID_OP_X     = 2'b01;
  localparam logic [1:0] VID_OP_Y     = 2'b10;
  localparam logic [1:0] VID_OP_PIXEL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET_Y,
    ST_SET_X,
    ST_PUT,
    ST_DONE
  } fill_state_e;

  typedef struct packed {
    logic [1:0]  opcode;
    logic        we;
    logic [31:0] data;
  } vid_bus_t;

  // Exclusive end coordinate of a span, clipped to the bitmap edge.
  // The sum is 10 bits wide so org+len never wraps.
  function automatic logic [9:0] clip_end(input logic [8:0] org,
                                          input logic [8:0] len,
                                          input logic [9:0] lim);
    logic [9:0] sum;
    sum = {1'b0, org} + {1'b0, len};
    return (sum > lim) ? lim : sum;
  endfunction

endpackage

// File: rtl/rect_fill_controller_video_bus_mux.sv
// Video bus arbiter: the CPU owns the bus while the engine is idle, the
// engine owns it otherwise. CPU writes attempted while the engine owns the
// bus are stalled and dropped, never queued.
module video_bus_mux
  import rect_fill_controller_pkg::*;
(
  input  logic     engine_sel,
  input  vid_bus_t cpu_bus,
  input  vid_bus_t eng_bus,
  output vid_bus_t vid_bus,
  output logic     cpu_stall
);

  // Pure combinational select so the CPU path has no added latency in idle.
  always_comb begin
    vid_bus   = engine_sel ? eng_bus : cpu_bus;
    cpu_stall = engine_sel & cpu_bus.we;
  end

endmodule

// File: rtl/rect_fill_controller.sv
// Rectangle fill engine: walks the clipped rectangle row by row, issuing
// Y, then (X, pixel) pairs to the video card, and hands the bus back to the
// CPU when finished.
module rect_fill_controller
  import rect_fill_controller_pkg::*;
#(
  parameter int IN_WIDTH  = VID_IN_WIDTH,
  parameter int IN_HEIGHT = VID_IN_HEIGHT
) (
  input  logic        CLK_mips,
  input  logic        RST,
  input  logic        start,
  input  logic [8:0]  x0,
  input  logic [8:0]  y0,
  input  logic [8:0]  w,
  input  logic [8:0]  h,
  input  logic [1:0]  color,
  output logic        busy,
  output logic        done,
  input  logic [1:0]  cpu_opcode,
  input  logic        cpu_WE,
  input  logic [31:0] cpu_write_data,
  output logic        cpu_stall,
  output logic [1:0]  vid_opcode,
  output logic        vid_WE,
  output logic [31:0] vid_write_data
);

  localparam logic [9:0] W_LIM = 10'(IN_WIDTH);
  localparam logic [9:0] H_LIM = 10'(IN_HEIGHT);

  fill_state_e state_q, state_d;
  logic [8:0]  cx_q, cx_d;
  logic [8:0]  cy_q, cy_d;
  logic [8:0]  x_org_q, x_org_d;   // row restart column
  logic [9:0]  x_end_q, x_end_d;
  logic [9:0]  y_end_q, y_end_d;
  logic [1:0]  color_q, color_d;

  vid_bus_t cpu_bus, eng_bus, vid_bus;
  logic     empty_rect;

  assign empty_rect = (w == 9'd0) || (h == 9'd0) ||
                      ({1'b0, x0} >= W_LIM) || ({1'b0, y0} >= H_LIM);

  // Next-state, counter update and engine bus drive, all decoded from state.
  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    x_org_d = x_org_q;
    x_end_d = x_end_q;
    y_end_d = y_end_q;
    color_d = color_q;
    eng_bus = '{opcode: VID_OP_NONE, we: 1'b0, data: 32'h0};
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          color_d = color;
          cx_d    = x0;
          cy_d    = y0;
          x_org_d = x0;
          x_end_d = clip_end(x0, w, W_LIM);
          y_end_d = clip_end(y0, h, H_LIM);
          state_d = empty_rect ? ST_DONE : ST_SET_Y;
        end
      end
      ST_SET_Y: begin
        eng_bus = '{opcode: VID_OP_Y, we: 1'b1, data: {23'h0, cy_q}};
        state_d = ST_SET_X;
      end
      ST_SET_X: begin
        eng_bus = '{opcode: VID_OP_X, we: 1'b1, data: {23'h0, cx_q}};
        state_d = ST_PUT;
      end
      ST_PUT: begin
        eng_bus = '{opcode: VID_OP_PIXEL, we: 1'b1, data: {30'h0, color_q}};
        if (({1'b0, cx_q} + 10'd1) < x_end_q) begin
          cx_d    = cx_q + 9'd1;
          state_d = ST_SET_X;
        end else if (({1'b0, cy_q} + 10'd1) < y_end_q) begin
          cy_d    = cy_q + 9'd1;
          cx_d    = x_org_q;
          state_d = ST_SET_Y;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers; reset aborts any fill in progress at once.
  always_ff @(posedge CLK_mips or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      x_org_q <= '0;
      x_end_q <= '0;
      y_end_q <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      x_org_q <= x_org_d;
      x_end_q <= x_end_d;
      y_end_q <= y_end_d;
      color_q <= color_d;
    end
  end

  // Status outputs are pure decodes of the state register.
  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
  end

  assign cpu_bus = '{opcode: cpu_opcode, we: cpu_WE, data: cpu_write_data};

  video_bus_mux u_mux (
    .engine_sel (busy),
    .cpu_bus    (cpu_bus),
    .eng_bus    (eng_bus),
    .vid_bus    (vid_bus),
    .cpu_stall  (cpu_stall)
  );

  assign vid_opcode     = vid_bus.opcode;
  assign vid_WE         = vid_bus.we;
  assign vid_write_data = vid_bus.data;

endmodule

// File: tb/tb_rect_fill_controller.sv
// Directed bench for rect_fill_controller: write sequences, cycle counts,
// clipping, empty rectangles, CPU stall/pass-through and mid-fill reset.
module tb_rect_fill_controller;

  logic        CLK_mips = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  x0 = '0, y0 = '0, w = '0, h = '0;
  logic [1:0]  color = '0;
  logic        busy, done;
  logic [1:0]  cpu_opcode = '0;
  logic        cpu_WE = 1'b0;
  logic [31:0] cpu_write_data = '0;
  logic        cpu_stall;
  logic [1:0]  vid_opcode;
  logic        vid_WE;
  logic [31:0] vid_write_data;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int cyc;
  logic [33:0] wq[$];
  logic [33:0] eq[$];

  always #5 CLK_mips = ~CLK_mips;

  rect_fill_controller dut (
    .CLK_mips       (CLK_mips),
    .RST            (RST),
    .start          (start),
    .x0             (x0),
    .y0             (y0),
    .w              (w),
    .h              (h),
    .color          (color),
    .busy           (busy),
    .done           (done),
    .cpu_opcode     (cpu_opcode),
    .cpu_WE         (cpu_WE),
    .cpu_write_data (cpu_write_data),
    .cpu_stall      (cpu_stall),
    .vid_opcode     (vid_opcode),
    .vid_WE         (vid_WE),
    .vid_write_data (vid_write_data)
  );

  // Log every video write the engine issues, mid-cycle.
  always @(negedge CLK_mips) begin
    if (busy && vid_WE) wq.push_back({vid_opcode, vid_write_data});
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK_mips);
    #1;
  endtask

  function automatic logic [33:0] mk(input logic [1:0] op, input int v);
    return {op, 32'(v)};
  endfunction

  task automatic cmp_writes(input string tag);
    chk({tag, "_nwr"}, 64'(wq.size()), 64'(eq.size()));
    for (int i = 0; i < eq.size() && i < wq.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), 64'(wq[i]), 64'(eq[i]));
  endtask

  // Issue one fill; optionally hammer the CPU port and re-pulse start while busy.
  task automatic run_fill(input logic [8:0] ax, input logic [8:0] ay,
                          input logic [8:0] aw, input logic [8:0] ah,
                          input logic [1:0] ac, input bit disturb,
                          output int ncyc);
    wq.delete();
    x0 = ax; y0 = ay; w = aw; h = ah; color = ac;
    start = 1'b1;
    step();
    start = 1'b0;
    ncyc = 1;
    while (!done && ncyc < 200) begin
      if (disturb) begin
        cpu_WE = 1'b1; cpu_opcode = 2'b11; cpu_write_data = 32'hDEADBEEF;
        #1;
        chk("stall_busy", 64'(cpu_stall), 64'd1);
        if (ncyc == 3) begin
          start = 1'b1; x0 = 9'd0; y0 = 9'd0; w = 9'd1; h = 9'd1; color = 2'd3;
        end
      end
      step();
      start = 1'b0;
      ncyc++;
    end
    chk("busy_in_done", 64'(busy), 64'd1);
    step();
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_done", 64'(done), 64'd0);
    if (disturb) chk("idle_stall", 64'(cpu_stall), 64'd0);
    cpu_WE = 1'b0; cpu_opcode = 2'b00; cpu_write_data = 32'h0;
  endtask

  initial begin
    int d0;
    // Reset state
    step(); step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_stall", 64'(cpu_stall), 64'd0);
    chk("rst_vidwe", 64'(vid_WE), 64'd0);
    RST = 1'b0;
    step();

    // Idle pass-through, same cycle
    cpu_WE = 1'b1; cpu_opcode = 2'b11; cpu_write_data = 32'h1234_5678;
    #1;
    chk("pt_op", 64'(vid_opcode), 64'd3);
    chk("pt_we", 64'(vid_WE), 64'd1);
    chk("pt_data", 64'(vid_write_data), 64'h1234_5678);
    chk("pt_stall", 64'(cpu_stall), 64'd0);
    cpu_WE = 1'b0; cpu_opcode = 2'b00; cpu_write_data = 32'h0;
    step();

    // 3x2 fill at (10,20), colour 2, with CPU traffic and a stray start
    run_fill(9'd10, 9'd20, 9'd3, 9'd2, 2'd2, 1'b1, cyc);
    chk("f32_cycles", 64'(cyc), 64'd15);
    eq.delete();
    for (int r = 0; r < 2; r++) begin
      eq.push_back(mk(2'b10, 20 + r));
      for (int c = 0; c < 3; c++) begin
        eq.push_back(mk(2'b01, 10 + c));
        eq.push_back(mk(2'b11, 2));
      end
    end
    cmp_writes("f32");

    // Clipped at the bottom-right corner, started right after the last one
    run_fill(9'd318, 9'd239, 9'd5, 9'd5, 2'd1, 1'b0, cyc);
    chk("clip_cycles", 64'(cyc), 64'd6);
    eq.delete();
    eq.push_back(mk(2'b10, 239));
    eq.push_back(mk(2'b01, 318));
    eq.push_back(mk(2'b11, 1));
    eq.push_back(mk(2'b01, 319));
    eq.push_back(mk(2'b11, 1));
    cmp_writes("clip");

    // Single pixel
    run_fill(9'd0, 9'd0, 9'd1, 9'd1, 2'd3, 1'b0, cyc);
    chk("px1_cycles", 64'(cyc), 64'd4);
    eq.delete();
    eq.push_back(mk(2'b10, 0));
    eq.push_back(mk(2'b01, 0));
    eq.push_back(mk(2'b11, 3));
    cmp_writes("px1");

    // Empty rectangles
    eq.delete();
    run_fill(9'd10, 9'd10, 9'd0, 9'd4, 2'd1, 1'b0, cyc);
    chk("w0_cycles", 64'(cyc), 64'd1);
    cmp_writes("w0");
    run_fill(9'd10, 9'd10, 9'd4, 9'd0, 2'd1, 1'b0, cyc);
    chk("h0_cycles", 64'(cyc), 64'd1);
    cmp_writes("h0");
    run_fill(9'd320, 9'd10, 9'd3, 9'd2, 2'd1, 1'b0, cyc);
    chk("x320_cycles", 64'(cyc), 64'd1);
    cmp_writes("x320");
    run_fill(9'd5, 9'd240, 9'd3, 9'd2, 2'd1, 1'b0, cyc);
    chk("y240_cycles", 64'(cyc), 64'd1);
    cmp_writes("y240");

    // Reset during the second pixel write of a 3x2 fill
    wq.delete();
    d0 = done_cnt;
    x0 = 9'd10; y0 = 9'd20; w = 9'd3; h = 9'd2; color = 2'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    chk("pre_rst_op", 64'(vid_opcode), 64'd3);
    RST = 1'b1;
    cpu_WE = 1'b1; cpu_opcode = 2'b01; cpu_write_data = 32'h55;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_stall", 64'(cpu_stall), 64'd0);
    chk("arst_pt_data", 64'(vid_write_data), 64'h55);
    step(); step(); step();
    RST = 1'b0;
    cpu_WE = 1'b0; cpu_opcode = 2'b00; cpu_write_data = 32'h0;
    step(); step();
    chk("arst_no_done", 64'(done_cnt - d0), 64'd0);
    chk("arst_nwr", 64'(wq.size()), 64'd4);

    // Engine works normally after the abort
    run_fill(9'd100, 9'd50, 9'd1, 9'd2, 2'd0, 1'b0, cyc);
    chk("post_cycles", 64'(cyc), 64'd7);
    eq.delete();
    eq.push_back(mk(2'b10, 50));
    eq.push_back(mk(2'b01, 100));
    eq.push_back(mk(2'b11, 0));
    eq.push_back(mk(2'b10, 51));
    eq.push_back(mk(2'b01, 100));
    eq.push_back(mk(2'b11, 0));
    cmp_writes("post");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
